// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Multi-cycle fetch / next-PC controller for the cpu31 core. Owns the
// architectural PC and steps each instruction through FETCH (handshake with
// instruction memory) and a single EXEC cycle in which the datapath commits
// and the next PC is selected. Fetch timeouts and misaligned jr targets park
// the block in a sticky FAULT state that only reset leaves.
//
// Ports
//   clk         system clock, all state updates on the rising edge
//   rst         synchronous, active-high reset
//   ena         run enable; sampled in IDLE and at the end of EXEC
//   pc_sel      next-PC source: 00 seq, 01 branch, 10 jump, 11 jr (EXEC only)
//   branch_imm  signed branch offset in words
//   jump_idx    J-type target index
//   jr_target   register jump target
//   fetch_ack   imem has data for imem_addr; ignored outside FETCH
//   fetch_req   fetch request to imem (high throughout FETCH)
//   imem_addr   pc - TEXT_BASE, modulo 2^32
//   pc          architectural PC
//   inst_valid  one-cycle pulse in EXEC; datapath executes and commits
//   busy        high in FETCH or EXEC
//   fault       sticky fault flag
//   fault_code  00 none, 01 fetch timeout, 10 misaligned jr
//   retire_cnt  committed instruction count, wraps at 2^32
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0040_0000,
    parameter logic [31:0] TEXT_BASE = 32'h0040_0000,
    parameter int unsigned TIMEOUT   = 16     // legal range 2..65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic [1:0]  pc_sel,
    input  logic [15:0] branch_imm,
    input  logic [25:0] jump_idx,
    input  logic [31:0] jr_target,
    input  logic        fetch_ack,
    output logic        fetch_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic        inst_valid,
    output logic        busy,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [31:0] retire_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_FAULT = 2'd3
    } state_e;

    localparam logic [1:0] SEL_SEQ    = 2'b00;
    localparam logic [1:0] SEL_BRANCH = 2'b01;
    localparam logic [1:0] SEL_JUMP   = 2'b10;
    localparam logic [1:0] SEL_JR     = 2'b11;

    localparam logic [1:0] CODE_NONE    = 2'b00;
    localparam logic [1:0] CODE_TIMEOUT = 2'b01;
    localparam logic [1:0] CODE_JR      = 2'b10;

    // Last wait-counter value tolerated without an ack; the fault fires on
    // the TIMEOUT-th consecutive FETCH cycle that still sees no ack.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] retire_q, retire_d;
    logic [15:0] wait_q, wait_d;
    logic [1:0]  code_q, code_d;

    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        jr_misaligned;

    // ------------------------------------------------------------------
    // Next-PC selection. Only consumed in EXEC, so it is free to follow
    // the select inputs in every other state.
    // ------------------------------------------------------------------
    assign pc_plus4      = pc_q + 32'd4;
    assign jr_misaligned = (pc_sel == SEL_JR) && (jr_target[1:0] != 2'b00);

    always_comb begin
        next_pc = pc_plus4;
        case (pc_sel)
            SEL_SEQ:    next_pc = pc_plus4;
            // Word offset: sign-extend to 30 bits, then scale by 4.
            SEL_BRANCH: next_pc = pc_plus4 + {{14{branch_imm[15]}}, branch_imm, 2'b00};
            SEL_JUMP:   next_pc = {pc_plus4[31:28], jump_idx, 2'b00};
            SEL_JR:     next_pc = jr_target;
            default:    next_pc = pc_plus4;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d  = state_q;
        pc_d     = pc_q;
        retire_d = retire_q;
        wait_d   = wait_q;
        code_d   = code_q;

        case (state_q)
            S_IDLE: begin
                if (ena) begin
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                // ena is deliberately not looked at: an issued fetch is
                // always completed (or times out).
                if (fetch_ack) begin
                    state_d = S_EXEC;
                    wait_d  = '0;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_FAULT;
                    code_d  = CODE_TIMEOUT;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end

            S_EXEC: begin
                if (jr_misaligned) begin
                    // Nothing commits: PC and retire count stay put.
                    state_d = S_FAULT;
                    code_d  = CODE_JR;
                end else begin
                    pc_d     = next_pc;
                    retire_d = retire_q + 32'd1;
                    state_d  = ena ? S_FETCH : S_IDLE;
                end
            end

            S_FAULT: begin
                state_d = S_FAULT;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers, synchronous reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every register samples the
        // pre-edge values, independent of statement order.
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            retire_q <= '0;
            wait_q   <= '0;
            code_q   <= CODE_NONE;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            retire_q <= retire_d;
            wait_q   <= wait_d;
            code_q   <= code_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from state or taken straight from registers, so no
    // input reaches an output combinationally.
    // ------------------------------------------------------------------
    assign fetch_req  = (state_q == S_FETCH);
    assign inst_valid = (state_q == S_EXEC);
    assign busy       = (state_q == S_FETCH) || (state_q == S_EXEC);
    assign fault      = (state_q == S_FAULT);
    assign fault_code = code_q;
    assign pc         = pc_q;
    assign retire_cnt = retire_q;
    assign imem_addr  = pc_q - TEXT_BASE;

endmodule
